program_loader: RTL
===================

Name: program_loader

Overview:
- Writer-side companion to the CPU's memory fetch path. It loads a program image into the 16x8 instruction/data memory before the CPU runs.
- Accepts a byte stream over a valid/ready handshake and writes consecutive addresses from 0. It then reads the image back and checks an 8-bit additive checksum.
- Releases the CPU (cpu_run) only on a clean load.

Parameters:
- ADDR_W, 4, memory address width.
- DATA_W, 8, memory word width (instruction format I|opcode[2:0]|addr[3:0]).
- DEPTH, 16, number of memory words; legal count range is 1..DEPTH.

Ports:
- CLK  input  1  system clock, all state updates on rising edge.
- RST  input  1  reset, asynchronous, active-high.
- start  input  1  begin load; sampled only in IDLE, DONE, ERROR.
- count  input  5  number of words to load; latched on accepted start.
- in_valid  input  1  in_data holds a valid byte.
- in_data  input  DATA_W  program byte.
- in_ready  output  1  loader can accept a byte this cycle.
- mem_addr  output  ADDR_W  memory address (registered).
- mem_wdata  output  DATA_W  memory write data (registered).
- mem_write  output  1  memory write strobe (registered, one cycle per word).
- mem_rdata  input  DATA_W  memory read data (DR).
- busy  output  1  high in LOAD and VERIFY.
- done  output  1  high in DONE.
- cpu_run  output  1  CPU enable; high only in DONE.
- error  output  1  high in ERROR.
- err_code  output  2  0 none, 1 illegal count, 2 checksum mismatch.
- checksum  output  DATA_W  running sum of accepted bytes, mod 2^DATA_W.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - All outputs are 0, including mem_write, so no write is issued after RST rises.
  - Internal counters and sums are cleared.
- States: IDLE, LOAD, VERIFY, DONE, ERROR. in_ready is high only in LOAD.
- IDLE, DONE or ERROR with start=1:
  - count is latched; done, error, err_code and cpu_run clear on the same edge.
  - count==0 or count>DEPTH: go to ERROR with err_code=1. No memory access.
  - Otherwise: wr_addr=0, checksum=0, go to LOAD.
- LOAD:
  - Transfer occurs on an edge where in_valid && in_ready.
  - On a transfer: mem_write<=1, mem_addr<=wr_addr, mem_wdata<=in_data, checksum<=checksum+in_data (wraps mod 256), wr_addr++.
  - No transfer: mem_write<=0.
  - Back-to-back transfers give one write per cycle. Gaps in in_valid stall without side effects.
  - On the transfer of word count-1, go to VERIFY. in_ready drops the next cycle, so no extra byte is accepted.
  - start is ignored.
- VERIFY:
  - mem_write=0.
  - Issue read addresses 0..count-1 on mem_addr, one per cycle.
  - The memory registers its read on the edge that samples mem_addr. The loader therefore samples mem_rdata exactly 2 edges after the edge that set mem_addr.
  - rd_sum accumulates mod 256.
  - VERIFY lasts count+2 cycles.
  - After the last sample: rd_sum==checksum goes to DONE; otherwise go to ERROR with err_code=2.
  - start is ignored.
- DONE: done=1, cpu_run=1; hold until start or RST.
- ERROR: error=1, err_code held; cpu_run=0; hold until start or RST.
- Address wrap: with count=DEPTH the last write is to address DEPTH-1. wr_addr is never used past that.
- The checksum output stays valid (last load's value) in DONE and ERROR.

Test Plan:
1. start, count=4; bytes 0x81,0x12,0x7F,0x05 with in_valid held high -> mem_write pulses on 4 consecutive cycles at addr 0..3 with matching data; checksum=0x17; then done=1, cpu_run=1, error=0.
2. start, count=0 (then count=17) -> one cycle later error=1, err_code=1, mem_write never asserts, in_ready stays 0.
3. count=3, in_valid toggling every other cycle -> exactly 3 writes at addr 0,1,2; address advances only on transfers; 4th offered byte not accepted.
4. count=4 load of 0x81,0x12,0x7F,0x05 with the memory model corrupting addr 2 to 0x7E on readback -> error=1, err_code=2, cpu_run=0.
5. count=16, all bytes 0xFF -> writes at addr 0..15, checksum=0xF0, VERIFY 18 cycles, done=1.
6. RST pulsed mid-LOAD after 2 writes -> all outputs 0 immediately, no further mem_write; new start with count=1, byte 0x3C -> checksum=0x3C, done=1.

Source files
------------

// File: rtl/program_loader_if.sv
// program_loader_if
//   Bundles the loader's two buses into one connection:
//   - byte stream: in_valid / in_data from the source, in_ready back to the source
//   - memory bus:  mem_addr / mem_wdata / mem_write to the memory, mem_rdata back
//   modport master : loader side (drives in_ready and the memory command)
//   modport slave  : environment side (byte source plus memory)
interface program_loader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  in_valid, in_data, mem_rdata,
    output in_ready, mem_addr, mem_wdata, mem_write
  );

  modport slave (
    output in_valid, in_data, mem_rdata,
    input  in_ready, mem_addr, mem_wdata, mem_write
  );
endinterface

// File: rtl/program_loader.sv
// program_loader
//   Loads a program image into the 16x8 instruction/data memory ahead of the
//   CPU. Bytes arrive over a valid/ready stream and are written to consecutive
//   addresses starting at 0. The image is then read back and its 8-bit additive
//   sum is compared with the sum of the accepted bytes. The CPU is released
//   (o_cpu_run) only after a clean load.
// Ports
//   i_clk       system clock, rising edge
//   i_rst       asynchronous active-high reset
//   i_start     begin a load (sampled in IDLE, DONE, ERROR)
//   i_count     number of words to load, legal 1..DEPTH
//   bus         stream + memory bus (master side)
//   o_busy      high in LOAD and VERIFY
//   o_done      high in DONE
//   o_cpu_run   CPU enable, high only in DONE
//   o_error     high in ERROR
//   o_err_code  0 none, 1 illegal count, 2 checksum mismatch
//   o_checksum  sum of accepted bytes mod 2^DATA_W
module program_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W:0]   i_count,
  program_loader_if.master  bus,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_cpu_run,
  output logic              o_error,
  output logic [1:0]        o_err_code,
  output logic [DATA_W-1:0] o_checksum
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_VERIFY = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_wr_cnt;
  logic [CNT_W-1:0]  r_rd_cnt;
  logic [DATA_W-1:0] r_rd_sum;
  logic [DATA_W-1:0] r_checksum;
  logic [1:0]        r_err_code;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_write;

  logic              w_xfer;
  logic              w_bad_count;
  logic [DATA_W-1:0] w_rd_sum_next;

  assign w_xfer        = bus.in_valid && (r_state == ST_LOAD);
  assign w_bad_count   = (i_count == '0) || (i_count > DEPTH_C);
  assign w_rd_sum_next = r_rd_sum + bus.mem_rdata;

  assign bus.in_ready  = (r_state == ST_LOAD);
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_write = r_mem_write;

  assign o_busy     = (r_state == ST_LOAD) || (r_state == ST_VERIFY);
  assign o_done     = (r_state == ST_DONE);
  assign o_cpu_run  = (r_state == ST_DONE);
  assign o_error    = (r_state == ST_ERROR);
  assign o_err_code = r_err_code;
  assign o_checksum = r_checksum;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_rd_sum    <= '0;
      r_checksum  <= '0;
      r_err_code  <= 2'd0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_write <= 1'b0;
    end else begin
      r_mem_write <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (i_start) begin
            r_count    <= i_count;
            r_err_code <= 2'd0;
            if (w_bad_count) begin
              // Previous checksum is left untouched so it stays observable.
              r_state    <= ST_ERROR;
              r_err_code <= 2'd1;
            end else begin
              r_wr_cnt   <= '0;
              r_checksum <= '0;
              r_state    <= ST_LOAD;
            end
          end
        end

        ST_LOAD: begin
          if (w_xfer) begin
            r_mem_write <= 1'b1;
            r_mem_addr  <= r_wr_cnt[ADDR_W-1:0];
            r_mem_wdata <= bus.in_data;
            r_checksum  <= r_checksum + bus.in_data;
            r_wr_cnt    <= r_wr_cnt + ONE_C;
            if (r_wr_cnt == r_count - ONE_C) begin
              r_state  <= ST_VERIFY;
              r_rd_cnt <= '0;
              r_rd_sum <= '0;
            end
          end
        end

        ST_VERIFY: begin
          // Cycle k drives read address k (k < count). The memory registers
          // the read on the next edge, so the data for address k-2 is
          // present during cycle k. Last sample lands in cycle count+1.
          r_rd_cnt <= r_rd_cnt + ONE_C;
          if (r_rd_cnt < r_count)
            r_mem_addr <= r_rd_cnt[ADDR_W-1:0];
          if (r_rd_cnt >= TWO_C)
            r_rd_sum <= w_rd_sum_next;
          if (r_rd_cnt == r_count + ONE_C) begin
            if (w_rd_sum_next == r_checksum) begin
              r_state <= ST_DONE;
            end else begin
              r_state    <= ST_ERROR;
              r_err_code <= 2'd2;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
